line_merge_engine: RTL and testbench

//  Multi-cycle, parametrised 2048 move/merge engine for an N x N board.
//  It replaces the single-shot 4x4 move logic with a start/busy/done handshake and processes one line per cycle.

---
 rtl/line_merge_engine.sv | 210 +++++++++++++++++++++
 tb/tb_line_merge_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_merge_engine.sv
// line_merge_engine: multi-cycle 2048 move/merge engine, one board line per RUN cycle.
// Define WIN_DETECT_EN to add the win output and WIN_VAL parameter.
module line_merge_engine #(
   parameter int N       = 4,
   parameter int TILE_W  = 12,
   parameter int SCORE_W = 20
`ifdef WIN_DETECT_EN
   ,
   parameter int WIN_VAL = 2048
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            direction,
   input  logic [N*N*TILE_W-1:0] board_in,
   output logic                  busy,
   output logic                  done,
   output logic [N*N*TILE_W-1:0] board_out,
   output logic [SCORE_W-1:0]    score_update,
   output logic                  moved
`ifdef WIN_DETECT_EN
   ,
   output logic                  win
`endif
);

   localparam int IW = $clog2(N + 1);
   localparam int PW = $clog2(N);
   localparam int CW = $clog2(N * N);
   localparam int SW = SCORE_W + TILE_W + 1;
   localparam logic [TILE_W-1:0] MaxTile = {1'b1, {(TILE_W - 1){1'b0}}};
   localparam logic [SW-1:0] ScoreMax = {{(SW - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                     state_q, state_d;
   logic [IW-1:0]              line_q, line_d;
   logic [3:0]                 dir_q, dir_d;
   logic [N*N-1:0][TILE_W-1:0] work_q, work_d;
   logic [SCORE_W-1:0]         acc_q, acc_d;
   logic                       mv_q, mv_d;
   logic [N*N-1:0][TILE_W-1:0] bout_q, bout_d;
   logic [SCORE_W-1:0]         score_q, score_d;
   logic                       moved_q, moved_d;
`ifdef WIN_DETECT_EN
   logic                       win_acc_q, win_acc_d;
   logic                       win_q, win_d;
   logic                       line_hit;
`endif

   logic                       dir_onehot;
   int                         lsel;
   logic [N-1:0][TILE_W-1:0]   line_in, line_out;
   logic [SW-1:0]              acc_sum;
   logic [IW-1:0]              cnt;
   logic [PW-1:0]              last_pos;
   logic                       can_merge;
   logic [TILE_W-1:0]          v;

   // Map (line, position-from-destination-edge) onto the flat [row][col] cell index.
   function automatic logic [CW-1:0] cell_idx(input logic [3:0] dir, input int l, input int p);
      int r, c;
      case (dir)
         4'b0001: begin r = p;         c = l;         end
         4'b0010: begin r = N - 1 - p; c = l;         end
         4'b0100: begin r = l;         c = p;         end
         default: begin r = l;         c = N - 1 - p; end
      endcase
      return CW'(r * N + c);
   endfunction

   assign dir_onehot = (direction != 4'd0) && ((direction & (direction - 4'd1)) == 4'd0);

   // Single pass: slide non-zero tiles toward index 0, merging into the last placed tile
   // only if that tile did not itself come from a merge.
   always_comb begin
      lsel      = (line_q < IW'(N)) ? int'(line_q) : 0;
      line_in   = '0;
      line_out  = '0;
      acc_sum   = {{(SW - SCORE_W){1'b0}}, acc_q};
      cnt       = '0;
      last_pos  = '0;
      can_merge = 1'b0;
      v         = '0;
`ifdef WIN_DETECT_EN
      line_hit  = 1'b0;
`endif
      for (int p = 0; p < N; p++) begin
         line_in[p] = work_q[cell_idx(dir_q, lsel, p)];
      end
      for (int i = 0; i < N; i++) begin
         v = line_in[i];
         if (v != '0) begin
            if (can_merge && line_out[last_pos] == v && v != MaxTile) begin
               line_out[last_pos] = {v[TILE_W-2:0], 1'b0};
               acc_sum = acc_sum + SW'(line_out[last_pos]);
               if (acc_sum > ScoreMax) acc_sum = ScoreMax;
`ifdef WIN_DETECT_EN
               if (line_out[last_pos] == TILE_W'(WIN_VAL)) line_hit = 1'b1;
`endif
               can_merge = 1'b0;
            end else begin
               last_pos = PW'(cnt);
               line_out[last_pos] = v;
               cnt = cnt + IW'(1);
               can_merge = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      dir_d     = dir_q;
      work_d    = work_q;
      acc_d     = acc_q;
      mv_d      = mv_q;
      bout_d    = bout_q;
      score_d   = score_q;
      moved_d   = moved_q;
`ifdef WIN_DETECT_EN
      win_acc_d = win_acc_q;
      win_d     = win_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start && dir_onehot) begin
               state_d   = StRun;
               dir_d     = direction;
               work_d    = board_in;
               acc_d     = '0;
               mv_d      = 1'b0;
               line_d    = '0;
`ifdef WIN_DETECT_EN
               win_acc_d = 1'b0;
               win_d     = 1'b0;
`endif
            end
         end
         StRun: begin
            if (line_q == IW'(N)) begin
               // All lines processed: publish the result for the DONE cycle.
               state_d = StDone;
               bout_d  = work_q;
               score_d = acc_q;
               moved_d = mv_q;
`ifdef WIN_DETECT_EN
               win_d   = win_acc_q;
`endif
            end else begin
               for (int p = 0; p < N; p++) begin
                  work_d[cell_idx(dir_q, lsel, p)] = line_out[p];
               end
               acc_d  = (|acc_sum[SW-1:SCORE_W]) ? {SCORE_W{1'b1}} : acc_sum[SCORE_W-1:0];
               mv_d   = mv_q | (line_out != line_in);
               line_d = line_q + IW'(1);
`ifdef WIN_DETECT_EN
               win_acc_d = win_acc_q | line_hit;
`endif
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         line_q    <= '0;
         dir_q     <= '0;
         work_q    <= '0;
         acc_q     <= '0;
         mv_q      <= 1'b0;
         bout_q    <= '0;
         score_q   <= '0;
         moved_q   <= 1'b0;
`ifdef WIN_DETECT_EN
         win_acc_q <= 1'b0;
         win_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         dir_q     <= dir_d;
         work_q    <= work_d;
         acc_q     <= acc_d;
         mv_q      <= mv_d;
         bout_q    <= bout_d;
         score_q   <= score_d;
         moved_q   <= moved_d;
`ifdef WIN_DETECT_EN
         win_acc_q <= win_acc_d;
         win_q     <= win_d;
`endif
      end
   end

   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign board_out    = bout_q;
   assign score_update = score_q;
   assign moved        = moved_q;
`ifdef WIN_DETECT_EN
   assign win          = win_q;
`endif

endmodule

// File: tb/tb_line_merge_engine.sv
// tb_line_merge_engine: table vectors, randomized moves against a queue-based model,
// and hand-written handshake/reset sequences for line_merge_engine (N=4).
module tb_line_merge_engine;

   localparam int N   = 4;
   localparam int TW  = 12;
   localparam int SCW = 20;
   localparam int BW  = N * N * TW;
   localparam int LAT = N + 1;

   localparam logic [3:0] DUp = 4'b0001, DDown = 4'b0010, DLeft = 4'b0100, DRight = 4'b1000;

   logic           clk = 1'b0;
   logic           rst, start, busy, done, moved;
   logic [3:0]     direction;
   logic [BW-1:0]  board_in, board_out;
   logic [SCW-1:0] score_update;
`ifdef WIN_DETECT_EN
   logic           win;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   line_merge_engine #(.N(N), .TILE_W(TW), .SCORE_W(SCW)) dut (
      .clk(clk), .rst(rst), .start(start), .direction(direction), .board_in(board_in),
      .busy(busy), .done(done), .board_out(board_out), .score_update(score_update),
      .moved(moved)
`ifdef WIN_DETECT_EN
      , .win(win)
`endif
   );

   typedef struct packed {
      logic [3:0]        dir;
      logic [1:0]        ln;
      logic [3:0][11:0]  in_l;
      logic [3:0][11:0]  ex_l;
      logic [19:0]       score;
      logic              mv;
      logic              wn;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Lines are given in geometric order: index 0 is the top row or the left column.
   function automatic vec_t mkv(input logic [3:0] d, input int ln, input int a0, input int a1,
                                input int a2, input int a3, input int e0, input int e1,
                                input int e2, input int e3, input int sc, input bit mv,
                                input bit wn);
      vec_t t;
      t.dir = d; t.ln = 2'(ln);
      t.in_l[0] = 12'(a0); t.in_l[1] = 12'(a1); t.in_l[2] = 12'(a2); t.in_l[3] = 12'(a3);
      t.ex_l[0] = 12'(e0); t.ex_l[1] = 12'(e1); t.ex_l[2] = 12'(e2); t.ex_l[3] = 12'(e3);
      t.score = 20'(sc); t.mv = mv; t.wn = wn;
      return t;
   endfunction

   function automatic logic [BW-1:0] put_line(input logic [3:0] d, input int ln,
                                              input logic [3:0][11:0] l);
      logic [BW-1:0] b;
      b = '0;
      for (int i = 0; i < N; i++) begin
         if (d == DUp || d == DDown) b[(i * N + ln) * TW +: TW] = l[i];
         else                        b[(ln * N + i) * TW +: TW] = l[i];
      end
      return b;
   endfunction

   function automatic void pos(input logic [3:0] d, input int l, input int p,
                               output int row, output int col);
      case (d)
         DUp:     begin row = p;         col = l;         end
         DDown:   begin row = N - 1 - p; col = l;         end
         DLeft:   begin row = l;         col = p;         end
         default: begin row = l;         col = N - 1 - p; end
      endcase
   endfunction

   // Reference: gather non-zero tiles from the destination edge, pair equal neighbours once.
   function automatic void ref_move(input logic [BW-1:0] b, input logic [3:0] d,
                                    output logic [BW-1:0] o, output int sc, output bit wn);
      int unsigned q[$];
      int unsigned r[$];
      int row, col, k;
      o = b; sc = 0; wn = 1'b0;
      for (int l = 0; l < N; l++) begin
         q.delete(); r.delete();
         for (int p = 0; p < N; p++) begin
            pos(d, l, p, row, col);
            if (b[(row * N + col) * TW +: TW] != 0) q.push_back(b[(row * N + col) * TW +: TW]);
         end
         k = 0;
         while (k < q.size()) begin
            if (k + 1 < q.size() && q[k] == q[k + 1] && q[k] != 2048) begin
               r.push_back(2 * q[k]);
               sc += 2 * q[k];
               if (2 * q[k] == 2048) wn = 1'b1;
               k += 2;
            end else begin
               r.push_back(q[k]);
               k++;
            end
         end
         while (r.size() < N) r.push_back(0);
         for (int p = 0; p < N; p++) begin
            pos(d, l, p, row, col);
            o[(row * N + col) * TW +: TW] = TW'(r[p]);
         end
      end
      if (sc > 2 ** SCW - 1) sc = 2 ** SCW - 1;
   endfunction

   function automatic logic [TW-1:0] rnd_tile();
      int k;
      k = $urandom_range(0, 5);
      if (k == 0) return '0;
      if (k == 5) return TW'(1) << $urandom_range(6, 11);
      return TW'(1) << k;
   endfunction

   // Accept a move and wait (bounded) for done; returns edges from acceptance to done.
   task automatic run_move(input logic [BW-1:0] b, input logic [3:0] d, output int lat,
                           output bit busy_ok);
      board_in = b; direction = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy_ok = busy;
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic check_result(input string tag, input logic [BW-1:0] eb, input int esc,
                               input bit emv, input bit ewn, input int lat, input bit busy_ok);
      chk({tag, " latency"}, BW'(lat), BW'(LAT));
      chk({tag, " busy"}, BW'(busy_ok), BW'(1));
      chk({tag, " board"}, board_out, eb);
      chk({tag, " score"}, BW'(score_update), BW'(esc));
      chk({tag, " moved"}, BW'(moved), BW'(emv));
`ifdef WIN_DETECT_EN
      chk({tag, " win"}, BW'(win), BW'(ewn));
`else
      if (ewn) begin end
`endif
      @(posedge clk); #1;
      chk({tag, " pulse"}, BW'({busy, done}), BW'(0));
   endtask

   initial begin
      logic [BW-1:0] b, eb, got;
      int            lat, sc, ndone;
      bit            bok, wn, bad;
      logic [3:0]    d;

      rst = 1'b1; start = 1'b0; direction = '0; board_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy/done/moved", BW'({busy, done, moved}), BW'(0));
      chk("reset score", BW'(score_update), BW'(0));
      chk("reset board", board_out, '0);
      rst = 1'b0;

      vecs[0]  = mkv(DLeft,  0, 2, 2, 2, 2,       4, 4, 0, 0,        8, 1, 0);
      vecs[1]  = mkv(DUp,    1, 0, 2, 0, 2,       4, 0, 0, 0,        4, 1, 0);
      vecs[2]  = mkv(DRight, 2, 2, 2, 4, 0,       0, 0, 4, 4,        4, 1, 0);
      vecs[3]  = mkv(DRight, 3, 2048, 2048, 0, 0, 0, 0, 2048, 2048,  0, 1, 0);
      vecs[4]  = mkv(DLeft,  0, 2, 4, 8, 16,      2, 4, 8, 16,       0, 0, 0);
      vecs[5]  = mkv(DDown,  3, 2, 0, 2, 4,       0, 0, 4, 4,        4, 1, 0);
      vecs[6]  = mkv(DDown,  0, 2, 2, 2, 0,       0, 0, 2, 4,        4, 1, 0);
      vecs[7]  = mkv(DUp,    2, 4, 4, 8, 8,       8, 16, 0, 0,      24, 1, 0);
      vecs[8]  = mkv(DLeft,  1, 0, 0, 0, 2,       2, 0, 0, 0,        0, 1, 0);
      vecs[9]  = mkv(DLeft,  0, 1024, 1024, 0, 0, 2048, 0, 0, 0,  2048, 1, 1);
      vecs[10] = mkv(DLeft,  0, 2, 4, 8, 16,      2, 4, 8, 16,       0, 0, 0);

      for (int i = 0; i < 11; i++) begin
         b  = put_line(vecs[i].dir, int'(vecs[i].ln), vecs[i].in_l);
         eb = put_line(vecs[i].dir, int'(vecs[i].ln), vecs[i].ex_l);
         run_move(b, vecs[i].dir, lat, bok);
         check_result($sformatf("vec%0d", i), eb, int'(vecs[i].score), vecs[i].mv, vecs[i].wn,
                      lat, bok);
      end

      for (int i = 0; i < 40; i++) begin
         for (int c = 0; c < N * N; c++) b[c * TW +: TW] = rnd_tile();
         d = 4'b0001 << $urandom_range(0, 3);
         ref_move(b, d, eb, sc, wn);
         run_move(b, d, lat, bok);
         check_result($sformatf("rnd%0d", i), eb, sc, eb != b, wn, lat, bok);
      end

      // Non-one-hot directions must be ignored.
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         board_in = put_line(DLeft, 0, {12'd2, 12'd2, 12'd2, 12'd2});
         direction = (i == 0) ? 4'b0000 : (i == 1) ? 4'b0011 : 4'b1100;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (busy || done) bad = 1'b1;
         repeat (6) begin
            @(posedge clk); #1;
            if (busy || done) bad = 1'b1;
         end
      end
      chk("bad direction ignored", BW'(bad), BW'(0));

      // Start re-pulsed during RUN with a different board: exactly one done, first result.
      b = put_line(DLeft, 0, {12'd2, 12'd2, 12'd2, 12'd2});
      ref_move(b, DLeft, eb, sc, wn);
      board_in = b; direction = DLeft; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      board_in = put_line(DUp, 1, {12'd8, 12'd8, 12'd0, 12'd0});
      direction = DUp; start = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      start = 1'b0;
      ndone = 0; got = '0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) begin ndone++; got = board_out; end
      end
      chk("restart during run done count", BW'(ndone), BW'(1));
      chk("restart during run board", got, eb);

      // Reset on the second RUN cycle discards the move and clears outputs.
      board_in = put_line(DLeft, 1, {12'd0, 12'd0, 12'd4, 12'd4});
      direction = DLeft; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrun reset busy/done/moved", BW'({busy, done, moved}), BW'(0));
      chk("midrun reset board", board_out, '0);
      chk("midrun reset score", BW'(score_update), BW'(0));
      bad = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (busy || done) bad = 1'b1;
      end
      chk("midrun reset no done", BW'(bad), BW'(0));

      // rst and start together: rst wins.
      board_in = put_line(DLeft, 0, {12'd2, 12'd2, 12'd2, 12'd2});
      direction = DLeft; rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rst beats start", BW'(busy), BW'(0));

      b = put_line(DRight, 2, {12'd2, 12'd2, 12'd4, 12'd0});
      ref_move(b, DRight, eb, sc, wn);
      run_move(b, DRight, lat, bok);
      check_result("after reset", eb, sc, 1'b1, wn, lat, bok);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
